// File: rtl/panda_pkg.sv
// Shared types for the panda fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package panda_pkg;

    // Architectural PC width. The fetch entry layout below is sized by it.
    localparam int unsigned XLEN = 32;

    // Canonical RISC-V NOP (addi x0, x0, 0).
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

    typedef enum logic {
        FetchRun,
        FetchDiscard
    } fetch_state_e;

endpackage

// File: rtl/panda_fetch_fifo.sv
// Generic synchronous FIFO with a synchronous clear.
// Latency: a push becomes visible at data_o one cycle later (no bypass).
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
//
// Ports: clk_i/rst_ni clock and async active-low reset; clear_i empties the FIFO
// and wins over push/pop; push_i/data_i write; pop_i/data_o read the head;
// empty_o/full_o/count_o report occupancy.
module panda_fetch_fifo #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic [DataWidth-1:0]         data_i,
    input  logic                         pop_i,
    output logic [DataWidth-1:0]         data_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [DataWidth-1:0] mem [Depth];
    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic [CntW-1:0]      count;
    logic                 do_push;
    logic                 do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == CntW'(Depth));
    assign count_o = count;
    assign data_o  = mem[rd_ptr];

    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the slot in the same cycle, so push-while-full is fine then.
    assign do_push = push_i & (~full_o | do_pop);

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/panda_fetch.sv
// Instruction fetch: in-order req/gnt/rvalid memory port feeding a {pc, instr} buffer for decode.
// Latency: gnt -> instr_valid_o at least 2 cycles (response registered in the buffer first).
// Backpressure: requests stop once outstanding + buffered reaches FifoDepth; decode stalls via instr_ready_i.
//
// Ports: clk_i/rst_ni clock and async active-low reset; pc_i/pc_en_o link to the PC
// register (pc_en_o pulses on every grant); flush_i squashes everything in flight;
// instr_req_o/instr_addr_o/instr_gnt_i/instr_rvalid_i/instr_rdata_i memory port;
// instr_valid_o/instr_ready_i/instr_o/instr_pc_o decode handshake; misalign_o sticky
// misaligned-PC flag.
// Build option: define PANDA_FETCH_MISALIGN_CHECK_EN to block fetches from PCs with
// pc_i[1:0] != 0 and raise misalign_o until the next flush; otherwise misalign_o is 0.
module panda_fetch
    import panda_pkg::*;
#(
    parameter int unsigned Width     = XLEN,
    parameter int unsigned FifoDepth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] pc_i,
    output logic             pc_en_o,
    input  logic             flush_i,
    output logic             instr_req_o,
    output logic [Width-1:0] instr_addr_o,
    input  logic             instr_gnt_i,
    input  logic             instr_rvalid_i,
    input  logic [31:0]      instr_rdata_i,
    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    output logic [31:0]      instr_o,
    output logic [Width-1:0] instr_pc_o,
    output logic             misalign_o
);

    localparam int unsigned CntW = $clog2(FifoDepth + 1);
    localparam int unsigned SumW = CntW + 1;

    fetch_state_e    state_q;
    logic [CntW-1:0] discard_q;
    logic [CntW-1:0] outstanding;
    logic [CntW-1:0] fifo_count;
    logic [CntW-1:0] pending_after;
    logic [Width-1:0] rsp_addr;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;
    logic            fifo_empty;
    logic            credit_ok;
    logic            issue_ok;
    logic            addr_ok;
    logic            keep_rsp;
    logic            pop_head;
    logic            unused_full;

    // Buffer space is reserved at grant time: a response always has a slot.
    assign credit_ok = (SumW'(outstanding) + SumW'(fifo_count)) < SumW'(FifoDepth);

    // rst_ni gating keeps the request low while reset is held, when the
    // cleared counters would otherwise advertise free credit.
    assign issue_ok    = rst_ni & (state_q == FetchRun) & ~flush_i & credit_ok;
    assign instr_req_o = issue_ok & addr_ok;
    assign instr_addr_o = pc_i;
    assign pc_en_o     = instr_req_o & instr_gnt_i;

    // Responses still owed by memory once this cycle's rvalid is consumed.
    assign pending_after = outstanding - CntW'(instr_rvalid_i);

    // Stale responses are dropped during DISCARD and in the flush cycle itself.
    assign keep_rsp   = instr_rvalid_i & (state_q == FetchRun) & ~flush_i;
    assign push_entry = {rsp_addr, instr_rdata_i};
    assign pop_head   = instr_valid_o & instr_ready_i;

`ifdef PANDA_FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    assign addr_ok    = ~misalign_q & (pc_i[1:0] == 2'b00);
    assign misalign_o = misalign_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            misalign_q <= 1'b0;
        end else if (flush_i) begin
            misalign_q <= 1'b0;
        end else if (issue_ok && pc_i[1:0] != 2'b00) begin
            misalign_q <= 1'b1;
        end
    end
`else
    assign addr_ok    = 1'b1;
    assign misalign_o = 1'b0;
`endif

    // Address queue: never cleared, every response in flight still pops it.
    panda_fetch_fifo #(
        .DataWidth (Width),
        .Depth     (FifoDepth)
    ) u_addr_q (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (1'b0),
        .push_i  (pc_en_o),
        .data_i  (pc_i),
        .pop_i   (instr_rvalid_i),
        .data_o  (rsp_addr),
        .empty_o (),
        .full_o  (unused_full),
        .count_o (outstanding)
    );

    panda_fetch_fifo #(
        .DataWidth ($bits(fetch_entry_t)),
        .Depth     (FifoDepth)
    ) u_entry_q (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (flush_i),
        .push_i  (keep_rsp),
        .data_i  (push_entry),
        .pop_i   (pop_head),
        .data_o  (head_entry),
        .empty_o (fifo_empty),
        .full_o  (),
        .count_o (fifo_count)
    );

    assign instr_valid_o = ~fifo_empty;
    assign instr_o       = instr_valid_o ? head_entry.instr : '0;
    assign instr_pc_o    = instr_valid_o ? head_entry.pc    : '0;

    // DISCARD counts down the responses that belong to the squashed path.
    // A flush in either state reloads the count from what is still owed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= FetchRun;
            discard_q <= '0;
        end else if (flush_i) begin
            discard_q <= pending_after;
            state_q   <= (pending_after != '0) ? FetchDiscard : FetchRun;
        end else if (state_q == FetchDiscard && instr_rvalid_i) begin
            discard_q <= discard_q - CntW'(1);
            if (discard_q == CntW'(1)) state_q <= FetchRun;
        end
    end

endmodule
